// File: rtl/sfx_pkg.sv
// Shared types for the sound-effect tone sequencer: effect ids, note ROM word, FSM states.
package sfx_pkg;

    localparam int NUM_FX = 4;

    typedef enum logic [1:0] {
        FX_MARCH = 2'd0,
        FX_SHOT  = 2'd1,
        FX_EXPL  = 2'd2,
        FX_UFO   = 2'd3
    } fx_id_t;

    typedef struct packed {
        logic       last;
        logic [3:0] tone;
        logic [3:0] dur;
    } note_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Highest set request bit wins; returns FX_MARCH when nothing is requested.
    function automatic fx_id_t pick_fx(input logic [NUM_FX-1:0] req);
        fx_id_t f;
        f = FX_MARCH;
        for (int i = 0; i < NUM_FX; i++) begin
            if (req[i]) f = fx_id_t'(2'(i));
        end
        return f;
    endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// Per-effect note table; empty slots read back as a terminating one-unit silent-tone note.
module sfx_note_rom
    import sfx_pkg::*;
(
    input  logic [1:0] fx,
    input  logic [2:0] idx,
    output note_word_t word
);

    always_comb begin
        word = '{last: 1'b1, tone: 4'd0, dur: 4'd1};
        case ({fx, idx})
            5'b00_000: word = '{last: 1'b1, tone: 4'd0,  dur: 4'd3};
            5'b01_000: word = '{last: 1'b0, tone: 4'd12, dur: 4'd1};
            5'b01_001: word = '{last: 1'b0, tone: 4'd9,  dur: 4'd1};
            5'b01_010: word = '{last: 1'b1, tone: 4'd5,  dur: 4'd1};
            5'b10_000: word = '{last: 1'b0, tone: 4'd2,  dur: 4'd2};
            5'b10_001: word = '{last: 1'b0, tone: 4'd1,  dur: 4'd2};
            5'b10_010: word = '{last: 1'b1, tone: 4'd0,  dur: 4'd4};
            5'b11_000: word = '{last: 1'b0, tone: 4'd9,  dur: 4'd2};
            5'b11_001: word = '{last: 1'b0, tone: 4'd11, dur: 4'd2};
            5'b11_010: word = '{last: 1'b0, tone: 4'd9,  dur: 4'd2};
            5'b11_011: word = '{last: 1'b1, tone: 4'd11, dur: 4'd2};
            default:   ;
        endcase
    end

endmodule

// File: rtl/sfx_tone_sequencer.sv
// Fixed-priority sound-effect sequencer: arbitrates requests, walks the note ROM, times notes and gaps.
module sfx_tone_sequencer
    import sfx_pkg::*;
#(
    parameter int TICK_DIV     = 31500,
    parameter int GAP_UNITS    = 1,
    parameter int NOTES_PER_FX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] fx_req,
    input  logic       mute,
    output logic [3:0] tone,
    output logic       sound_enable,
    output logic       busy,
    output logic [1:0] fx_id,
    output logic [1:0] state
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_UNITS - 1);
    localparam logic [2:0]  LAST_IDX   = 3'(NOTES_PER_FX - 1);

    state_t     st, nxt_st;
    fx_id_t     cur_fx, win, load_fx;
    logic [2:0] idx, load_idx;
    logic [15:0] presc, units;
    logic [3:0] cur_dur;
    logic       cur_last;
    logic       start, unit_end, note_end, gap_end, load;
    note_word_t word;

    assign state = st;
    assign fx_id = cur_fx;

    sfx_note_rom u_rom (
        .fx   (load_fx),
        .idx  (load_idx),
        .word (word)
    );

    always_comb begin
        win      = pick_fx(fx_req);
        start    = (|fx_req) && (st == ST_IDLE || win > cur_fx);
        unit_end = (presc == PRESC_LAST);
        note_end = (st == ST_NOTE) && unit_end && (units == {12'd0, cur_dur - 4'd1});
        gap_end  = (st == ST_GAP) && unit_end && (units == GAP_LAST);
        load_fx  = start ? win : cur_fx;
        load_idx = start ? 3'd0 : idx + 3'd1;
        nxt_st   = st;
        load     = 1'b0;
        // Preemption has priority over any note/gap boundary on the same edge.
        if (start) begin
            load   = 1'b1;
            nxt_st = ST_NOTE;
        end else if (note_end) begin
            if (cur_last) begin
                nxt_st = ST_IDLE;
            end else if (GAP_UNITS == 0) begin
                load   = 1'b1;
                nxt_st = ST_NOTE;
            end else begin
                nxt_st = ST_GAP;
            end
        end else if (gap_end) begin
            load   = 1'b1;
            nxt_st = ST_NOTE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= ST_IDLE;
            cur_fx       <= FX_MARCH;
            idx          <= 3'd0;
            presc        <= 16'd0;
            units        <= 16'd0;
            cur_dur      <= 4'd0;
            cur_last     <= 1'b0;
            tone         <= 4'd0;
            sound_enable <= 1'b0;
            busy         <= 1'b0;
        end else begin
            st           <= nxt_st;
            busy         <= (nxt_st != ST_IDLE);
            sound_enable <= (nxt_st == ST_NOTE) & ~mute;
            if (load) begin
                cur_fx   <= load_fx;
                idx      <= load_idx;
                tone     <= word.tone;
                cur_dur  <= (word.dur == 4'd0) ? 4'd1 : word.dur;
                cur_last <= word.last | (load_idx == LAST_IDX);
                presc    <= 16'd0;
                units    <= 16'd0;
            end else if (nxt_st != st) begin
                presc <= 16'd0;
                units <= 16'd0;
            end else if (st != ST_IDLE) begin
                presc <= unit_end ? 16'd0 : presc + 16'd1;
                if (unit_end) units <= units + 16'd1;
            end
        end
    end

endmodule
